// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Two-requester front end to a single memory port. Requester 0 is the core,
//   requester 1 is debug/DMA. One transaction is outstanding at a time: a
//   request is latched in IDLE, issued to memory in ISSUE (held until
//   mem_ready), then completed in WAIT by mem_valid or by a timeout.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_enable/command    per-requester strobe and command (0 read, 1 write)
//   req_address0/1        per-requester byte address
//   req_write_data0/1     per-requester store data
//   req_strobe0/1         per-requester byte enables
//   req_ready             both high in IDLE, else both low
//   req_valid/req_error   completion pulse to the granted requester; error = timeout
//   req_read_data         read data, nonzero only on a normal completion
//   mem_ready/mem_enable  memory handshake for the issued command
//   mem_command/address/write_data/strobe  latched command, zero when not enabled
//   mem_valid/mem_read_data  memory completion and return data
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new request, round-robin grant on acceptance
// ISSUE | drive latched command, wait for mem_ready
// WAIT  | wait for mem_valid or timeout, then complete to the requester

module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_enable,
  input  logic [1:0]  req_command,
  input  logic [31:0] req_address0,
  input  logic [31:0] req_address1,
  input  logic [31:0] req_write_data0,
  input  logic [31:0] req_write_data1,
  input  logic [3:0]  req_strobe0,
  input  logic [3:0]  req_strobe1,
  output logic [1:0]  req_ready,
  output logic [1:0]  req_valid,
  output logic        req_error,
  output logic [31:0] req_read_data,
  input  logic        mem_ready,
  output logic        mem_enable,
  output logic        mem_command,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_strobe,
  input  logic        mem_valid,
  input  logic [31:0] mem_read_data
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id_q, grant_id_d;
  logic        cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strobe_q, strobe_d;
  logic [7:0]  count_q, count_d;

  logic grant_sel;
  logic accept;
  logic complete_ok;
  logic complete_to;

  // Round robin only matters on a tie: the requester not granted last wins.
  always_comb begin
    grant_sel = 1'b0;
    case (req_enable)
      2'b01:   grant_sel = 1'b0;
      2'b10:   grant_sel = 1'b1;
      2'b11:   grant_sel = ~last_grant_q;
      default: grant_sel = 1'b0;
    endcase
    accept      = (state_q == ST_IDLE) && (req_enable != 2'b00);
    complete_ok = (state_q == ST_WAIT) && mem_valid;
    // A coincident mem_valid takes priority over the timeout.
    complete_to = (state_q == ST_WAIT) && !mem_valid && (count_q == TIMEOUT_LIMIT);
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      cmd_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      strobe_q     <= 4'h0;
      count_q      <= 8'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strobe_q     <= strobe_d;
      count_q      <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (mem_ready) state_d = ST_WAIT;
      ST_WAIT:  if (complete_ok || complete_to) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture and timeout counter
  always_comb begin
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strobe_d     = strobe_q;
    count_d      = count_q;

    if (accept) begin
      last_grant_d = grant_sel;
      grant_id_d   = grant_sel;
      if (grant_sel) begin
        cmd_d    = req_command[1];
        addr_d   = req_address1;
        wdata_d  = req_write_data1;
        strobe_d = req_strobe1;
      end else begin
        cmd_d    = req_command[0];
        addr_d   = req_address0;
        wdata_d  = req_write_data0;
        strobe_d = req_strobe0;
      end
    end

    // The counter stops at the limit because the timeout leaves WAIT.
    if ((state_q == ST_ISSUE) && mem_ready) begin
      count_d = 8'h0;
    end else if ((state_q == ST_WAIT) && !complete_ok && !complete_to) begin
      count_d = count_q + 8'h1;
    end
  end

  // Outputs
  always_comb begin
    req_ready      = (state_q == ST_IDLE) ? 2'b11 : 2'b00;
    req_valid      = 2'b00;
    req_error      = complete_to;
    req_read_data  = complete_ok ? mem_read_data : 32'h0;
    if (complete_ok || complete_to) begin
      req_valid[grant_id_q] = 1'b1;
    end

    mem_enable     = (state_q == ST_ISSUE) && mem_ready;
    mem_command    = mem_enable ? cmd_q    : 1'b0;
    mem_address    = mem_enable ? addr_q   : 32'h0;
    mem_write_data = mem_enable ? wdata_q  : 32'h0;
    mem_strobe     = mem_enable ? strobe_q : 4'h0;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Cycle-by-cycle directed vectors for memory_arbiter (TIMEOUT_CYCLES = 4),
// followed by a hand-written asynchronous reset-in-WAIT sequence.

module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_enable;
  logic [1:0]  req_command;
  logic [31:0] req_address0, req_address1;
  logic [31:0] req_write_data0, req_write_data1;
  logic [3:0]  req_strobe0, req_strobe1;
  logic [1:0]  req_ready;
  logic [1:0]  req_valid;
  logic        req_error;
  logic [31:0] req_read_data;
  logic        mem_ready;
  logic        mem_enable;
  logic        mem_command;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_strobe;
  logic        mem_valid;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  memory_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_enable      (req_enable),
    .req_command     (req_command),
    .req_address0    (req_address0),
    .req_address1    (req_address1),
    .req_write_data0 (req_write_data0),
    .req_write_data1 (req_write_data1),
    .req_strobe0     (req_strobe0),
    .req_strobe1     (req_strobe1),
    .req_ready       (req_ready),
    .req_valid       (req_valid),
    .req_error       (req_error),
    .req_read_data   (req_read_data),
    .mem_ready       (mem_ready),
    .mem_enable      (mem_enable),
    .mem_command     (mem_command),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_strobe      (mem_strobe),
    .mem_valid       (mem_valid),
    .mem_read_data   (mem_read_data)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  en;
    logic [1:0]  cmd;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  s0, s1;
    logic        mr, mv;
    logic [31:0] mrd;
    logic [1:0]  rdy, vld;
    logic        err;
    logic [31:0] rdata;
    logic        men, mcmd;
    logic [31:0] maddr, mwd;
    logic [3:0]  mstb;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] D0 = 32'h11111111;
  localparam logic [31:0] D1 = 32'h22222222;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic void add(
    input logic [31:0] rst, en, cmd, a0, a1, d0, d1, s0, s1, mr, mv, mrd,
    input logic [31:0] rdy, vld, err, rdata, men, mcmd, maddr, mwd, mstb);
    vec_t v;
    v.rst = rst[0];  v.en = en[1:0];  v.cmd = cmd[1:0];
    v.a0 = a0;  v.a1 = a1;  v.d0 = d0;  v.d1 = d1;
    v.s0 = s0[3:0];  v.s1 = s1[3:0];
    v.mr = mr[0];  v.mv = mv[0];  v.mrd = mrd;
    v.rdy = rdy[1:0];  v.vld = vld[1:0];  v.err = err[0];  v.rdata = rdata;
    v.men = men[0];  v.mcmd = mcmd[0];  v.maddr = maddr;  v.mwd = mwd;  v.mstb = mstb[3:0];
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1;
    req_enable = 2'b00;  req_command = 2'b00;
    req_address0 = 32'h0;  req_address1 = 32'h0;
    req_write_data0 = 32'h0;  req_write_data1 = 32'h0;
    req_strobe0 = 4'h0;  req_strobe1 = 4'h0;
    mem_ready = 1'b0;  mem_valid = 1'b0;  mem_read_data = 32'h0;

    // rst en cmd a0 a1 d0 d1 s0 s1 mr mv mrd | rdy vld err rdata men mcmd maddr mwd mstb
    // Core read, data returned 3 cycles after mem_enable
    add(1,0,0,'h100,'h300,'hA5A5A5A5,D1,'hF,5,1,0,0,            3,0,0,0,0,0,0,0,0);
    add(0,1,0,'h100,'h300,'hA5A5A5A5,D1,'hF,5,1,0,0,            3,0,0,0,0,0,0,0,0);
    add(0,0,0,'h100,'h300,'hA5A5A5A5,D1,'hF,5,1,0,0,            0,0,0,0,1,0,'h100,'hA5A5A5A5,'hF);
    add(0,0,0,'h100,'h300,'hA5A5A5A5,D1,'hF,5,1,0,0,            0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h100,'h300,'hA5A5A5A5,D1,'hF,5,1,0,0,            0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h100,'h300,'hA5A5A5A5,D1,'hF,5,1,1,'hDEADBEEF,   0,1,0,'hDEADBEEF,0,0,0,0,0);
    add(0,0,0,'h100,'h300,'hA5A5A5A5,D1,'hF,5,1,1,'h12345678,   3,0,0,0,0,0,0,0,0);
    // Contention from reset: grants 0,1,0,1; requests during completion are not taken
    add(1,3,2,'h100,'h300,D0,D1,'hF,5,1,0,0,                    3,0,0,0,0,0,0,0,0);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,0,0,                    3,0,0,0,0,0,0,0,0);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,0,0,                    0,0,0,0,1,0,'h100,D0,'hF);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,1,'hAAAA0000,           0,1,0,'hAAAA0000,0,0,0,0,0);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,0,0,                    3,0,0,0,0,0,0,0,0);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,0,0,                    0,0,0,0,1,1,'h300,D1,5);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,1,'hBBBB1111,           0,2,0,'hBBBB1111,0,0,0,0,0);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,0,0,                    3,0,0,0,0,0,0,0,0);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,0,0,                    0,0,0,0,1,0,'h100,D0,'hF);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,1,'hCCCC2222,           0,1,0,'hCCCC2222,0,0,0,0,0);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,0,0,                    3,0,0,0,0,0,0,0,0);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,0,0,                    0,0,0,0,1,1,'h300,D1,5);
    add(0,3,2,'h100,'h300,D0,D1,'hF,5,1,1,'hDDDD3333,           0,2,0,'hDDDD3333,0,0,0,0,0);
    add(0,0,0,'h100,'h300,D0,D1,'hF,5,1,0,0,                    3,0,0,0,0,0,0,0,0);
    // Backpressure: write to 0x200 strobe 0011 held 5 cycles; mem_valid in ISSUE ignored
    add(0,1,1,'h200,'h300,'hCAFEF00D,D1,3,5,0,0,0,              3,0,0,0,0,0,0,0,0);
    add(0,0,0,'h999,'h300,0,D1,'hF,5,0,0,0,                     0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h999,'h300,0,D1,'hF,5,0,1,'h99,                  0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h999,'h300,0,D1,'hF,5,0,0,0,                     0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h999,'h300,0,D1,'hF,5,0,0,0,                     0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h999,'h300,0,D1,'hF,5,0,0,0,                     0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h999,'h300,0,D1,'hF,5,1,0,0,                     0,0,0,0,1,1,'h200,'hCAFEF00D,3);
    add(0,0,0,'h999,'h300,0,D1,'hF,5,1,0,0,                     0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h999,'h300,0,D1,'hF,5,1,1,'h13572468,            0,1,0,'h13572468,0,0,0,0,0);
    // Timeout on requester 1: error 4 cycles after entering WAIT, late mem_valid ignored
    add(0,2,0,'h100,'h400,D0,D1,'hF,5,1,0,0,                    3,0,0,0,0,0,0,0,0);
    add(0,0,0,'h100,'h400,D0,D1,'hF,5,1,0,0,                    0,0,0,0,1,0,'h400,D1,5);
    add(0,0,0,'h100,'h400,D0,D1,'hF,5,1,0,'hFFFFFFFF,           0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h100,'h400,D0,D1,'hF,5,1,0,'hFFFFFFFF,           0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h100,'h400,D0,D1,'hF,5,1,0,'hFFFFFFFF,           0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h100,'h400,D0,D1,'hF,5,1,0,'hFFFFFFFF,           0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h100,'h400,D0,D1,'hF,5,1,0,'hFFFFFFFF,           0,2,1,0,0,0,0,0,0);
    add(0,0,0,'h100,'h400,D0,D1,'hF,5,1,1,'h55,                 3,0,0,0,0,0,0,0,0);
    // mem_valid on the exact timeout cycle wins; request in completion cycle taken next cycle
    add(0,1,0,'h500,'h700,0,D1,'hF,5,1,0,0,                     3,0,0,0,0,0,0,0,0);
    add(0,0,0,'h500,'h700,0,D1,'hF,5,1,0,0,                     0,0,0,0,1,0,'h500,0,'hF);
    add(0,0,0,'h500,'h700,0,D1,'hF,5,1,0,0,                     0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h500,'h700,0,D1,'hF,5,1,0,0,                     0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h500,'h700,0,D1,'hF,5,1,0,0,                     0,0,0,0,0,0,0,0,0);
    add(0,0,0,'h500,'h700,0,D1,'hF,5,1,0,0,                     0,0,0,0,0,0,0,0,0);
    add(0,2,2,'h500,'h700,0,D1,'hF,5,1,1,'h600DDA7A,            0,1,0,'h600DDA7A,0,0,0,0,0);
    add(0,2,2,'h500,'h700,0,D1,'hF,5,1,0,0,                     3,0,0,0,0,0,0,0,0);
    add(0,0,0,'h500,'h700,0,D1,'hF,5,1,0,0,                     0,0,0,0,1,1,'h700,D1,5);

    #1;
    chk("reset_ready",     -1, 32'(req_ready), 32'h3);
    chk("reset_valid",     -1, 32'(req_valid), 32'h0);
    chk("reset_mem_en",    -1, 32'(mem_enable), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset           = vecs[i].rst;
      req_enable      = vecs[i].en;
      req_command     = vecs[i].cmd;
      req_address0    = vecs[i].a0;
      req_address1    = vecs[i].a1;
      req_write_data0 = vecs[i].d0;
      req_write_data1 = vecs[i].d1;
      req_strobe0     = vecs[i].s0;
      req_strobe1     = vecs[i].s1;
      mem_ready       = vecs[i].mr;
      mem_valid       = vecs[i].mv;
      mem_read_data   = vecs[i].mrd;
      #1;
      chk("req_ready",      i, 32'(req_ready),      32'(vecs[i].rdy));
      chk("req_valid",      i, 32'(req_valid),      32'(vecs[i].vld));
      chk("req_error",      i, 32'(req_error),      32'(vecs[i].err));
      chk("req_read_data",  i, req_read_data,       vecs[i].rdata);
      chk("mem_enable",     i, 32'(mem_enable),     32'(vecs[i].men));
      chk("mem_command",    i, 32'(mem_command),    32'(vecs[i].mcmd));
      chk("mem_address",    i, mem_address,         vecs[i].maddr);
      chk("mem_write_data", i, mem_write_data,      vecs[i].mwd);
      chk("mem_strobe",     i, 32'(mem_strobe),     32'(vecs[i].mstb));
    end

    // Last vector left the DUT in WAIT; reset asynchronously between edges.
    @(negedge clk);
    req_enable = 2'b00;
    mem_valid  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_ready",  100, 32'(req_ready),  32'h3);
    chk("async_rst_valid",  100, 32'(req_valid),  32'h0);
    chk("async_rst_mem_en", 100, 32'(mem_enable), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_valid = 1'b1;
    mem_read_data = 32'h77777777;
    #1;
    chk("post_rst_valid", 101, 32'(req_valid),     32'h0);
    chk("post_rst_data",  101, req_read_data,      32'h0);
    chk("post_rst_ready", 101, 32'(req_ready),     32'h3);
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    chk("post_rst_idle_ready", 102, 32'(req_ready), 32'h3);
    chk("post_rst_idle_valid", 102, 32'(req_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, the number of cycles in WAIT with no mem_valid before a transaction is aborted; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 req_enable[1:0]  input  2  per-requester request strobe; bit 0 = core, bit 1 = debug/DMA.
REQ-005 req_command[1:0]  input  2  per-requester command; 0 = read, 1 = write.
REQ-006 req_address0, req_address1  input  32 each  byte address.
REQ-007 req_write_data0, req_write_data1  input  32 each  store data.
REQ-008 req_strobe0, req_strobe1  input  4 each  byte write enables.
REQ-009 req_ready[1:0]  output  2  per-requester: a request is accepted this cycle if enabled.
REQ-010 req_valid[1:0]  output  2  per-requester single-cycle completion pulse.
REQ-011 req_error  output  1  qualifies req_valid: 1 = aborted by timeout.
REQ-012 req_read_data  output  32  read data, shared; meaningful only with req_valid.
REQ-013 mem_ready  input  1  memory can accept a command.
REQ-014 mem_enable  output  1  command strobe to memory.
REQ-015 mem_command  output  1  0 = read, 1 = write.
REQ-016 mem_address  output  32  latched address.
REQ-017 mem_write_data  output  32  latched store data.
REQ-018 mem_strobe  output  4  latched byte enables.
REQ-019 mem_valid  input  1  memory completion pulse.
REQ-020 mem_read_data  input  32  memory read data.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT; exactly one transaction is outstanding at a time.
REQ-022 IDLE: req_ready = 2'b11; all other states: req_ready = 2'b00.
REQ-023 Acceptance: in IDLE, any req_enable bit high selects a grant and latches that requester's command, address, write data and strobe, plus grant_id; next state is ISSUE.
REQ-024 Arbitration, single request: that requester is granted.
REQ-025 Arbitration, both requests: the requester not granted last wins (round robin); last_grant updates on every acceptance.
REQ-026 ISSUE: mem_enable = mem_ready and the mem_* outputs drive latched values; if mem_ready = 1, go to WAIT; otherwise hold in ISSUE with latched values stable.
REQ-027 WAIT: mem_enable = 0; on mem_valid = 1, in the same cycle (combinational): req_valid[grant_id] = 1, req_read_data = mem_read_data, req_error = 0; next state is IDLE.
REQ-028 Minimum latency: accept in cycle N, mem_enable in N+1, earliest req_valid in N+2.
REQ-029 Timeout counter, 8-bit: cleared on entry to WAIT, increments each WAIT cycle without mem_valid.
REQ-030 When the counter equals TIMEOUT_CYCLES with no mem_valid: req_valid[grant_id] = 1, req_error = 1, req_read_data = 0; next state is IDLE.
REQ-031 mem_valid coincident with the timeout cycle: normal completion wins and req_error = 0.
REQ-032 mem_valid in IDLE or ISSUE is ignored and produces no req_valid.
REQ-033 Outside a completion cycle: req_valid = 0, req_error = 0, req_read_data = 0.
REQ-034 A request asserted in the same cycle as a completion is not accepted, because req_ready = 0; it is accepted no earlier than the next cycle, in IDLE.
REQ-035 mem_command, mem_address, mem_write_data and mem_strobe are 0 when mem_enable = 0.

Reset
REQ-036 On reset: state = IDLE, last_grant = 1 (so requester 0 wins the first tie), counter = 0, latched fields = 0.
REQ-037 Reset values of outputs: req_ready = 2'b11, all other outputs 0.
REQ-038 Reset asserted mid-transaction abandons the transaction with no req_valid, and any later mem_valid is ignored.

Verification
REQ-039 Core read: req_enable = 01, address 0x100, mem_ready = 1, mem_valid 3 cycles later with data 0xDEADBEEF -> req_valid = 01, req_read_data = 0xDEADBEEF, req_error = 0.
REQ-040 Contention: both requests asserted every cycle from reset for 4 transactions -> grant order 0, 1, 0, 1.
REQ-041 Backpressure: mem_ready = 0 for 5 cycles after acceptance of a write to 0x200 with strobe 0011 -> mem_enable stays 0, then pulses once with address 0x200 and strobe 0011 when mem_ready rises.
REQ-042 Timeout: TIMEOUT_CYCLES = 4, no mem_valid -> req_valid with req_error = 1 exactly 4 cycles after entering WAIT, then return to IDLE; a late mem_valid produces no req_valid.
REQ-043 Reset in WAIT: assert reset asynchronously, then send mem_valid -> no req_valid; req_ready = 11 immediately on reset.
REQ-044 Edge: mem_valid on the exact timeout cycle -> req_error = 0 with the data forwarded; a new req_enable in the completion cycle is accepted on the following cycle.
